// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg: shared constants and types for the DDR arbiter slice.
//   MIG_CMD_WRITE / MIG_CMD_READ : app_cmd encodings of the MIG user interface
//   arb_state_e                  : arbiter FSM state
package ddr_arb_pkg;
  localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
  localparam logic [2:0] MIG_CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    ST_CALIB = 2'd0,
    ST_ARB   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } arb_state_e;
endpackage

// File: rtl/ddr_arb_addr_gen.sv
// ddr_arb_addr_gen: wrapping beat counter.
// It counts beats 0..FRAME_BEATS-1 and produces a matching byte address.
//   clk, rst_n : clock, async active-low reset
//   adv        : advance one beat
//   addr       : address of the current beat (beat * ADDR_STEP)
//   last       : current beat is the last one of the frame
module ddr_arb_addr_gen #(
  parameter int ADDR_WIDTH  = 27,
  parameter int ADDR_STEP   = 8,
  parameter int FRAME_BEATS = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  adv,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);
  localparam int CW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;

  logic [CW-1:0] cnt;

  assign last = (cnt == CW'(FRAME_BEATS - 1));

  // The address is kept as its own register rather than cnt*STEP so no
  // multiplier sits on the app_addr path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      addr <= '0;
    end else if (adv) begin
      if (last) begin
        cnt  <= '0;
        addr <= '0;
      end else begin
        cnt  <= cnt + CW'(1);
        addr <= addr + ADDR_WIDTH'(ADDR_STEP);
      end
    end
  end
endmodule

// File: rtl/ddr_arbiter.sv
// ddr_arbiter: shares the MIG user interface between a write stream and a
// frame-read stream, with round-robin arbitration and read throttling.
//   clk, rst_n              : DDR UI clock, async active-low reset
//   init_calib_complete     : MIG calibration done; commands only after it
//   wr_axis_*               : write beats from the write CDC FIFO (popped on tready)
//   rd_axis_*               : returned read beats to the read-back CDC FIFO
//   rd_axis_prog_full       : read-back FIFO nearly full, blocks new reads
//   app_*                   : MIG user interface (command, write data, read data)
//   stat_*                  : statistics counters
// Optional build macro DDR_ARB_STATS_EN builds the saturating statistics
// counters; without it the stat ports are tied to 0.
module ddr_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 27,
  parameter int BIT_WIDTH       = 128,
  parameter int ADDR_STEP       = 8,
  parameter int FRAME_BEATS     = 4096,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   init_calib_complete,
  input  logic                   wr_axis_tvalid,
  output logic                   wr_axis_tready,
  input  logic [BIT_WIDTH-1:0]   wr_axis_tdata,
  input  logic                   wr_axis_tlast,
  output logic                   rd_axis_tvalid,
  output logic [BIT_WIDTH-1:0]   rd_axis_tdata,
  output logic                   rd_axis_tlast,
  input  logic                   rd_axis_prog_full,
  output logic [ADDR_WIDTH-1:0]  app_addr,
  output logic [2:0]             app_cmd,
  output logic                   app_en,
  input  logic                   app_rdy,
  output logic [BIT_WIDTH-1:0]   app_wdf_data,
  output logic                   app_wdf_wren,
  output logic                   app_wdf_end,
  output logic [BIT_WIDTH/8-1:0] app_wdf_mask,
  input  logic                   app_wdf_rdy,
  input  logic [BIT_WIDTH-1:0]   app_rd_data,
  input  logic                   app_rd_data_valid,
  output logic [31:0]            stat_wr_beats,
  output logic [31:0]            stat_rd_beats,
  output logic [31:0]            stat_stall_cycles
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  arb_state_e            state_q, state_d;
  logic                  last_wr_q, last_wr_d;   // last grant was the write stream
  logic                  cmd_done_q, cmd_done_d;
  logic                  dat_done_q, dat_done_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [OW-1:0]         outstanding_q;
  logic                  wr_elig, rd_elig;
  logic                  cmd_acc, dat_acc, wr_pop, rd_issue;
  logic                  ret_last;
  logic                  rd_last_unused;
  logic [ADDR_WIDTH-1:0] ret_addr_unused;

  assign wr_elig = wr_axis_tvalid;
  assign rd_elig = !rd_axis_prog_full && (outstanding_q < OW'(MAX_OUTSTANDING));

  // MIG-side outputs decode only registered state, so they hold steady while
  // waiting on app_rdy / app_wdf_rdy. Write data comes straight from the
  // FIFO head, which cannot change until the pop.
  assign app_en       = ((state_q == ST_WRITE) && !cmd_done_q) || (state_q == ST_READ);
  assign app_cmd      = (state_q == ST_READ) ? MIG_CMD_READ : MIG_CMD_WRITE;
  assign app_addr     = (state_q == ST_WRITE) ? wr_addr_q :
                        (state_q == ST_READ)  ? rd_addr   : '0;
  assign app_wdf_wren = (state_q == ST_WRITE) && !dat_done_q;
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_data = app_wdf_wren ? wr_axis_tdata : '0;
  assign app_wdf_mask = '0;

  assign cmd_acc  = (state_q == ST_WRITE) && !cmd_done_q && app_rdy;
  assign dat_acc  = app_wdf_wren && app_wdf_rdy;
  // Pop in the cycle the later of command/data is accepted.
  assign wr_pop   = (state_q == ST_WRITE) && (cmd_done_q || cmd_acc) && (dat_done_q || dat_acc);
  assign rd_issue = (state_q == ST_READ) && app_rdy;
  assign wr_axis_tready = wr_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CALIB;
      last_wr_q  <= 1'b0;
      cmd_done_q <= 1'b0;
      dat_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_wr_q  <= last_wr_d;
      cmd_done_q <= cmd_done_d;
      dat_done_q <= dat_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_wr_d  = last_wr_q;
    cmd_done_d = cmd_done_q;
    dat_done_d = dat_done_q;
    case (state_q)
      ST_CALIB: if (init_calib_complete) state_d = ST_ARB;
      ST_ARB: begin
        cmd_done_d = 1'b0;
        dat_done_d = 1'b0;
        if (!init_calib_complete) begin
          state_d = ST_CALIB;
        end else if (wr_elig && (!rd_elig || !last_wr_q)) begin
          state_d   = ST_WRITE;
          last_wr_d = 1'b1;
        end else if (rd_elig) begin
          state_d   = ST_READ;
          last_wr_d = 1'b0;
        end
      end
      ST_WRITE: begin
        if (wr_pop) begin
          cmd_done_d = 1'b0;
          dat_done_d = 1'b0;
          // A calibration drop is honoured only once the beat is complete.
          state_d    = init_calib_complete ? ST_ARB : ST_CALIB;
        end else begin
          cmd_done_d = cmd_done_q | cmd_acc;
          dat_done_d = dat_done_q | dat_acc;
        end
      end
      ST_READ: if (rd_issue) state_d = init_calib_complete ? ST_ARB : ST_CALIB;
      default: state_d = ST_CALIB;
    endcase
  end

  // Write address restarts at 0 after the frame's last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      wr_addr_q <= '0;
    else if (wr_pop) wr_addr_q <= wr_axis_tlast ? '0 : wr_addr_q + ADDR_WIDTH'(ADDR_STEP);
  end

  // Issued-but-unreturned reads; simultaneous issue and return cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
    end else begin
      case ({rd_issue, app_rd_data_valid})
        2'b10:   outstanding_q <= outstanding_q + OW'(1);
        2'b01:   if (outstanding_q != '0) outstanding_q <= outstanding_q - OW'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // Return path: one register stage toward the read-back FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_axis_tvalid <= 1'b0;
      rd_axis_tdata  <= '0;
      rd_axis_tlast  <= 1'b0;
    end else begin
      rd_axis_tvalid <= app_rd_data_valid;
      rd_axis_tlast  <= app_rd_data_valid && ret_last;
      if (app_rd_data_valid) rd_axis_tdata <= app_rd_data;
    end
  end

  ddr_arb_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ADDR_STEP  (ADDR_STEP),
    .FRAME_BEATS(FRAME_BEATS)
  ) u_rd_addr (
    .clk  (clk),
    .rst_n(rst_n),
    .adv  (rd_issue),
    .addr (rd_addr),
    .last (rd_last_unused)
  );

  // Only the last-beat flag of the return counter is needed.
  ddr_arb_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ADDR_STEP  (ADDR_STEP),
    .FRAME_BEATS(FRAME_BEATS)
  ) u_ret_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .adv  (app_rd_data_valid),
    .addr (ret_addr_unused),
    .last (ret_last)
  );

`ifdef DDR_ARB_STATS_EN
  logic [31:0] wr_beats_q, rd_beats_q, stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_beats_q <= '0;
      rd_beats_q <= '0;
      stall_q    <= '0;
    end else begin
      if (wr_pop && (wr_beats_q != '1))                 wr_beats_q <= wr_beats_q + 32'd1;
      if (app_rd_data_valid && (rd_beats_q != '1))      rd_beats_q <= rd_beats_q + 32'd1;
      if (app_en && !app_rdy && (stall_q != '1))        stall_q    <= stall_q + 32'd1;
    end
  end

  assign stat_wr_beats     = wr_beats_q;
  assign stat_rd_beats     = rd_beats_q;
  assign stat_stall_cycles = stall_q;
`else
  assign stat_wr_beats     = '0;
  assign stat_rd_beats     = '0;
  assign stat_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_ddr_arbiter.sv
// tb_ddr_arbiter: directed self-checking bench for ddr_arbiter (FRAME_BEATS=4).
module tb_ddr_arbiter;
  localparam int AW = 27;
  localparam int BW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          init_calib_complete;
  logic          wr_axis_tvalid, wr_axis_tready, wr_axis_tlast;
  logic [BW-1:0] wr_axis_tdata;
  logic          rd_axis_tvalid, rd_axis_tlast, rd_axis_prog_full;
  logic [BW-1:0] rd_axis_tdata;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en, app_rdy;
  logic [BW-1:0] app_wdf_data;
  logic          app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [BW/8-1:0] app_wdf_mask;
  logic [BW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic [31:0]   stat_wr_beats, stat_rd_beats, stat_stall_cycles;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ddr_arbiter #(.FRAME_BEATS(4)) dut (
    .clk(clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
    .wr_axis_tvalid(wr_axis_tvalid), .wr_axis_tready(wr_axis_tready),
    .wr_axis_tdata(wr_axis_tdata), .wr_axis_tlast(wr_axis_tlast),
    .rd_axis_tvalid(rd_axis_tvalid), .rd_axis_tdata(rd_axis_tdata),
    .rd_axis_tlast(rd_axis_tlast), .rd_axis_prog_full(rd_axis_prog_full),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .stat_wr_beats(stat_wr_beats), .stat_rd_beats(stat_rd_beats),
    .stat_stall_cycles(stat_stall_cycles)
  );

  // Write source: a small table of beats, popped on tvalid&&tready.
  logic [BW-1:0] src_dat [0:7];
  logic          src_last [0:7];
  logic [3:0]    src_idx;
  logic [3:0]    src_len;
  logic          src_clr;

  always @(posedge clk)
    if (src_clr) src_idx <= 4'd0;
    else if (wr_axis_tvalid && wr_axis_tready) src_idx <= src_idx + 4'd1;

  assign wr_axis_tvalid = (src_idx < src_len);
  assign wr_axis_tdata  = src_dat[src_idx[2:0]];
  assign wr_axis_tlast  = src_last[src_idx[2:0]];

  // Monitor: log accepted commands, write data, pops and returned beats.
  logic          clr_log;
  int            cyc = 0;
  int            n_pop = 0;
  logic [2:0]    cmd_q [$];
  logic [AW-1:0] addr_q [$];
  int            ccyc_q [$];
  logic [BW-1:0] wdat_q [$];
  logic          rlast_q [$];
  logic [BW-1:0] rdat_q [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clr_log) begin
      cmd_q.delete(); addr_q.delete(); ccyc_q.delete();
      wdat_q.delete(); rlast_q.delete(); rdat_q.delete();
      n_pop <= 0;
    end else begin
      if (app_en && app_rdy) begin
        cmd_q.push_back(app_cmd); addr_q.push_back(app_addr); ccyc_q.push_back(cyc);
      end
      if (app_wdf_wren && app_wdf_rdy) wdat_q.push_back(app_wdf_data);
      if (wr_axis_tvalid && wr_axis_tready) n_pop <= n_pop + 1;
      if (rd_axis_tvalid) begin
        rlast_q.push_back(rd_axis_tlast); rdat_q.push_back(rd_axis_tdata);
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; src_clr = 1'b1; clr_log = 1'b1; src_len = 4'd0;
    init_calib_complete = 1'b0; rd_axis_prog_full = 1'b0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_valid = 1'b0; app_rd_data = '0;
    for (int i = 0; i < 8; i++) src_last[i] = 1'b0;
    run(3);
    src_clr = 1'b0; clr_log = 1'b0; rst_n = 1'b1;
  endtask

  logic       any_en, any_pop;
  logic [7:0] pat;
  int         n_rd;

  initial begin
    for (int i = 0; i < 8; i++) src_dat[i] = 128'hA0 + 128'(i);

    // Reset state
    do_reset();
    rst_n = 1'b0; #1;
    chk("rst_app_en", app_en, 0);
    chk("rst_app_addr", app_addr, 0);
    chk("rst_wren", app_wdf_wren, 0);
    chk("rst_tready", wr_axis_tready, 0);
    chk("rst_rd_tvalid", rd_axis_tvalid, 0);
    chk("rst_stats", {stat_wr_beats, stat_rd_beats, stat_stall_cycles}, 0);

    // Calibration gating, then round-robin W,R,W,R with both eligible
    do_reset();
    src_len = 4'd8;
    any_en = 1'b0; any_pop = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run(1);
      any_en  |= app_en;
      any_pop |= wr_axis_tready;
    end
    chk("calib_gate_en", any_en, 0);
    chk("calib_gate_pop", any_pop, 0);
    init_calib_complete = 1'b1;
    run(10);
    chk("rr_cnt_ge4", cmd_q.size() >= 4, 1);
    chk("rr_c0", {cmd_q[0], addr_q[0]}, {3'b000, 27'd0});
    chk("rr_c1", {cmd_q[1], addr_q[1]}, {3'b001, 27'd0});
    chk("rr_c2", {cmd_q[2], addr_q[2]}, {3'b000, 27'd8});
    chk("rr_c3", {cmd_q[3], addr_q[3]}, {3'b001, 27'd8});

    // Back-to-back writes, third beat is tlast
    do_reset();
    rd_axis_prog_full = 1'b1;
    src_len = 4'd4; src_last[2] = 1'b1;
    init_calib_complete = 1'b1;
    run(14);
    chk("b2b_pops", n_pop, 4);
    chk("b2b_cnt", cmd_q.size(), 4);
    chk("b2b_a0", {cmd_q[0], addr_q[0]}, {3'b000, 27'd0});
    chk("b2b_a1", addr_q[1], 8);
    chk("b2b_a2", addr_q[2], 16);
    chk("b2b_a3_wrap", addr_q[3], 0);
    chk("b2b_rate", ccyc_q[3] - ccyc_q[0], 6);
    chk("b2b_d1", wdat_q[1], 128'hA1);
    chk("b2b_d3", wdat_q[3], 128'hA3);
    chk("b2b_mask", app_wdf_mask, 0);
`ifdef DDR_ARB_STATS_EN
    chk("stat_wr", stat_wr_beats, 4);
`else
    chk("stat_wr", stat_wr_beats, 0);
`endif

    // Split acceptance: command taken at once, data held off
    do_reset();
    rd_axis_prog_full = 1'b1;
    src_len = 4'd1;
    app_wdf_rdy = 1'b0;
    init_calib_complete = 1'b1;
    run(6);
    chk("split_cmd1", cmd_q.size(), 1);
    chk("split_en_low", app_en, 0);
    chk("split_wren_held", app_wdf_wren, 1);
    chk("split_no_pop", n_pop, 0);
    app_wdf_rdy = 1'b1;
    run(5);
    chk("split_pop1", n_pop, 1);
    chk("split_cmd_still1", cmd_q.size(), 1);
    chk("split_dat1", wdat_q.size(), 1);

    // Calibration drops while a write is pending: finish it, then stop
    do_reset();
    rd_axis_prog_full = 1'b1;
    src_len = 4'd3;
    app_rdy = 1'b0;
    init_calib_complete = 1'b1;
    run(3);
    init_calib_complete = 1'b0;
    run(3);
    chk("cdrop_en_held", app_en, 1);
    app_rdy = 1'b1;
    run(8);
    chk("cdrop_pop1", n_pop, 1);
    chk("cdrop_cmd1", cmd_q.size(), 1);
    chk("cdrop_idle", app_en, 0);

    // Async reset mid-command abandons it without popping
    do_reset();
    rd_axis_prog_full = 1'b1;
    src_len = 4'd1;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    init_calib_complete = 1'b1;
    run(3);
    chk("arst_pre_en", app_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_en", app_en, 0);
    chk("arst_wren", app_wdf_wren, 0);
    chk("arst_nopop", n_pop, 0);

    // Read throttling on outstanding limit and prog_full; 1-cycle return latency
    do_reset();
    init_calib_complete = 1'b1;
    run(60);
    n_rd = cmd_q.size();
    chk("thr_16", n_rd, 16);
    app_rd_data_valid = 1'b1; app_rd_data = 128'hBEEF;
    #1;
    chk("lat_not_yet", rd_axis_tvalid, 0);
    run(1);
    app_rd_data_valid = 1'b0;
    chk("lat_valid", rd_axis_tvalid, 1);
    chk("lat_data", rd_axis_tdata, 128'hBEEF);
    run(6);
    chk("thr_17", cmd_q.size(), 17);
    rd_axis_prog_full = 1'b1;
    app_rd_data_valid = 1'b1;
    run(1);
    app_rd_data_valid = 1'b0;
    run(10);
    chk("thr_pfull", cmd_q.size(), 17);
    rd_axis_prog_full = 1'b0;
    run(6);
    chk("thr_18", cmd_q.size(), 18);

    // Frame wrap with FRAME_BEATS=4
    do_reset();
    init_calib_complete = 1'b1;
    run(40);
    chk("wrap_a1", addr_q[1], 8);
    chk("wrap_a3", addr_q[3], 24);
    chk("wrap_a4", addr_q[4], 0);
    for (int i = 0; i < 8; i++) begin
      app_rd_data_valid = 1'b1;
      app_rd_data = 128'h100 + 128'(i);
      run(1);
    end
    app_rd_data_valid = 1'b0;
    run(3);
    chk("wrap_nret", rlast_q.size(), 8);
    pat = '0;
    for (int i = 0; i < 8; i++) if (i < rlast_q.size()) pat[i] = rlast_q[i];
    chk("wrap_tlast", pat, 8'h88);
    chk("wrap_d0", rdat_q[0], 128'h100);
    chk("wrap_d7", rdat_q[7], 128'h107);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
